// File: rtl/v_upd_checker.sv
// Stateful protocol checker for the list update and list query buses.
// Shadows each product's key set and reports semantic and X violations one cycle after the beat.
module v_upd_checker #(
    parameter int PROD_N    = 4,
    parameter int PROD_ID_W = 2,
    parameter int ENTRIES_N = 8,
    parameter int KEY_W     = 16,
    parameter int SIZE_W    = 16,
    parameter int LEVEL_W   = 3,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_upd_vld,
    input  logic [PROD_ID_W-1:0]   i_upd_prod_id,
    input  logic [1:0]             i_upd_cmd,
    input  logic [KEY_W-1:0]       i_upd_key,
    input  logic [SIZE_W-1:0]      i_upd_size,
    input  logic                   i_lut_vld,
    input  logic [PROD_ID_W-1:0]   i_lut_prod_id,
    input  logic [LEVEL_W-1:0]     i_lut_level,
    output logic                   o_upd_err_vld,
    output logic [2:0]             o_upd_err_code,
    output logic [PROD_ID_W-1:0]   o_upd_err_prod_id,
    output logic                   o_lut_err_vld,
    output logic                   o_err_sticky,
    output logic [CNT_W-1:0]       o_err_cnt,
    output logic [PROD_N*4-1:0]    o_live_cnt
);

    localparam int IDX_W = (ENTRIES_N > 1) ? $clog2(ENTRIES_N) : 1;

    typedef enum logic [1:0] {CMD_CLEAR, CMD_ADD, CMD_DELETE, CMD_REPLACE} cmd_e;
    typedef enum logic [2:0] {
        ERR_NONE, ERR_FULL, ERR_DUP, ERR_MISS, ERR_ZSIZE, ERR_BADPROD, ERR_XVAL
    } err_e;

    logic [ENTRIES_N-1:0] slot_vld [PROD_N];
    logic [ENTRIES_N-1:0] vld_nxt  [PROD_N];
    logic [KEY_W-1:0]     slot_key [PROD_N][ENTRIES_N];

    logic             upd_hit, upd_free, upd_x, upd_bad, upd_err;
    logic [IDX_W-1:0] upd_hit_idx, upd_free_idx;
    logic             set_en, del_en, clr_en;
    err_e             upd_code;
    logic             lut_x, lut_bad, lut_err;
    logic [3:0]       lut_live;
    logic [1:0]       n_err;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;

    function automatic logic [3:0] popcnt(input logic [ENTRIES_N-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < ENTRIES_N; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    // Key match and lowest free slot for the update product; pre-update count for the query product.
    always_comb begin
        upd_hit      = 1'b0;
        upd_hit_idx  = '0;
        upd_free     = 1'b0;
        upd_free_idx = '0;
        lut_live     = '0;
        for (int p = 0; p < PROD_N; p++) begin
            if (i_upd_prod_id == PROD_ID_W'(p)) begin
                for (int e = 0; e < ENTRIES_N; e++) begin
                    if (slot_vld[p][e] && (slot_key[p][e] == i_upd_key) && !upd_hit) begin
                        upd_hit     = 1'b1;
                        upd_hit_idx = IDX_W'(e);
                    end
                    if (!slot_vld[p][e] && !upd_free) begin
                        upd_free     = 1'b1;
                        upd_free_idx = IDX_W'(e);
                    end
                end
            end
            if (i_lut_prod_id == PROD_ID_W'(p)) lut_live = popcnt(slot_vld[p]);
        end
    end

    assign upd_x   = $isunknown({i_upd_prod_id, i_upd_cmd}) ||
                     ((i_upd_cmd != 2'd0) && $isunknown({i_upd_key, i_upd_size}));
    assign upd_bad = int'(i_upd_prod_id) >= PROD_N;

    always_comb begin
        upd_code = ERR_NONE;
        set_en   = 1'b0;
        del_en   = 1'b0;
        clr_en   = 1'b0;
        if (i_upd_vld) begin
            if (upd_x)        upd_code = ERR_XVAL;
            else if (upd_bad) upd_code = ERR_BADPROD;
            else begin
                case (cmd_e'(i_upd_cmd))
                    CMD_CLEAR: clr_en = 1'b1;
                    CMD_ADD: begin
                        if (i_upd_size == '0) upd_code = ERR_ZSIZE;
                        else if (upd_hit)     upd_code = ERR_DUP;
                        else if (!upd_free)   upd_code = ERR_FULL;
                        else                  set_en   = 1'b1;
                    end
                    CMD_DELETE: begin
                        if (!upd_hit) upd_code = ERR_MISS;
                        else          del_en   = 1'b1;
                    end
                    CMD_REPLACE: begin
                        if (i_upd_size == '0) upd_code = ERR_ZSIZE;
                        else if (!upd_hit)    upd_code = ERR_MISS;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int p = 0; p < PROD_N; p++) begin
            vld_nxt[p] = slot_vld[p];
            if (i_upd_prod_id == PROD_ID_W'(p)) begin
                if (clr_en) vld_nxt[p] = '0;
                if (set_en) vld_nxt[p][upd_free_idx] = 1'b1;
                if (del_en) vld_nxt[p][upd_hit_idx]  = 1'b0;
            end
        end
    end

    assign upd_err = (upd_code != ERR_NONE);
    assign lut_x   = $isunknown({i_lut_prod_id, i_lut_level});
    assign lut_bad = int'(i_lut_prod_id) >= PROD_N;
    assign lut_err = i_lut_vld && (lut_x || lut_bad || (int'(i_lut_level) >= int'(lut_live)));

    // Saturating add: the carry bit means the sum passed all-ones.
    assign n_err   = {1'b0, upd_err} + {1'b0, lut_err};
    assign cnt_sum = {1'b0, o_err_cnt} + (CNT_W+1)'(n_err);
    assign cnt_nxt = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PROD_N; p++) slot_vld[p] <= '0;
            o_upd_err_vld     <= 1'b0;
            o_upd_err_code    <= '0;
            o_upd_err_prod_id <= '0;
            o_lut_err_vld     <= 1'b0;
            o_err_sticky      <= 1'b0;
            o_err_cnt         <= '0;
            o_live_cnt        <= '0;
        end else begin
            for (int p = 0; p < PROD_N; p++) begin
                slot_vld[p]          <= vld_nxt[p];
                o_live_cnt[4*p +: 4] <= popcnt(vld_nxt[p]);
            end
            o_upd_err_vld     <= upd_err;
            o_upd_err_code    <= upd_code;
            o_upd_err_prod_id <= upd_err ? i_upd_prod_id : '0;
            o_lut_err_vld     <= lut_err;
            o_err_sticky      <= o_err_sticky | upd_err | lut_err;
            o_err_cnt         <= cnt_nxt;
        end
    end

    // NOTE: key storage has no reset; a key is only ever read behind its cleared-on-reset valid bit.
    always_ff @(posedge clk) begin
        for (int p = 0; p < PROD_N; p++)
            for (int e = 0; e < ENTRIES_N; e++)
                if (set_en && (i_upd_prod_id == PROD_ID_W'(p)) && (upd_free_idx == IDX_W'(e)))
                    slot_key[p][e] <= i_upd_key;
    end

endmodule

// File: tb/tb_v_upd_checker.sv
// Self-checking bench for v_upd_checker: directed scenarios plus randomized beats against a set-based model.
module tb_v_upd_checker;

    localparam int PN  = 4;
    localparam int PW  = 3;
    localparam int EN  = 8;
    localparam int CW  = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          upd_vld;
    logic [PW-1:0] upd_prod_id;
    logic [1:0]    upd_cmd;
    logic [15:0]   upd_key;
    logic [15:0]   upd_size;
    logic          lut_vld;
    logic [PW-1:0] lut_prod_id;
    logic [2:0]    lut_level;
    logic          upd_err_vld;
    logic [2:0]    upd_err_code;
    logic [PW-1:0] upd_err_prod_id;
    logic          lut_err_vld;
    logic          err_sticky;
    logic [CW-1:0] err_cnt;
    logic [PN*4-1:0] live_cnt;

    int checks   = 0;
    int failures = 0;
    logic x_capable;

    v_upd_checker #(
        .PROD_N(PN), .PROD_ID_W(PW), .ENTRIES_N(EN), .KEY_W(16),
        .SIZE_W(16), .LEVEL_W(3), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_upd_vld(upd_vld), .i_upd_prod_id(upd_prod_id), .i_upd_cmd(upd_cmd),
        .i_upd_key(upd_key), .i_upd_size(upd_size),
        .i_lut_vld(lut_vld), .i_lut_prod_id(lut_prod_id), .i_lut_level(lut_level),
        .o_upd_err_vld(upd_err_vld), .o_upd_err_code(upd_err_code),
        .o_upd_err_prod_id(upd_err_prod_id), .o_lut_err_vld(lut_err_vld),
        .o_err_sticky(err_sticky), .o_err_cnt(err_cnt), .o_live_cnt(live_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd_vld = 1'b0; upd_prod_id = '0; upd_cmd = '0; upd_key = '0; upd_size = '0;
        lut_vld = 1'b0; lut_prod_id = '0; lut_level = '0;
    endtask

    task automatic upd(input int p, input int cmd, input int key, input int size);
        upd_vld = 1'b1; upd_prod_id = PW'(p); upd_cmd = 2'(cmd);
        upd_key = 16'(key); upd_size = 16'(size);
    endtask

    task automatic lut(input int p, input int level);
        lut_vld = 1'b1; lut_prod_id = PW'(p); lut_level = 3'(level);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        upd(0, 1, 1, 1);
        lut(0, 0);
        tick();
        tick();
        checks++; if (upd_err_vld !== 1'b0) begin failures++; $display("FAIL reset_upd_vld got=%b exp=0", upd_err_vld); end
        checks++; if (upd_err_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", upd_err_code); end
        checks++; if (lut_err_vld !== 1'b0) begin failures++; $display("FAIL reset_lut got=%b exp=0", lut_err_vld); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b exp=0", err_sticky); end
        checks++; if (err_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", err_cnt); end
        checks++; if (live_cnt !== '0) begin failures++; $display("FAIL reset_live got=%h exp=0", live_cnt); end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_full();
        for (int k = 1; k <= 8; k++) begin
            upd(0, 1, k, 5);
            tick();
            checks++; if (upd_err_vld !== 1'b0) begin failures++; $display("FAIL full_add%0d got=%b exp=0", k, upd_err_vld); end
        end
        upd(0, 1, 9, 5);
        tick();
        checks++; if (upd_err_vld !== 1'b1) begin failures++; $display("FAIL full_vld got=%b exp=1", upd_err_vld); end
        checks++; if (upd_err_code !== 3'd1) begin failures++; $display("FAIL full_code got=%0d exp=1", upd_err_code); end
        checks++; if (upd_err_prod_id !== 3'd0) begin failures++; $display("FAIL full_pid got=%0d exp=0", upd_err_prod_id); end
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL full_sticky got=%b exp=1", err_sticky); end
        idle();
        tick();
        checks++; if (upd_err_vld !== 1'b0) begin failures++; $display("FAIL full_pulse got=%b exp=0", upd_err_vld); end
        checks++; if (upd_err_code !== 3'd0) begin failures++; $display("FAIL full_code_idle got=%0d exp=0", upd_err_code); end
        checks++; if (live_cnt[3:0] !== 4'd8) begin failures++; $display("FAIL full_live got=%0d exp=8", live_cnt[3:0]); end
    endtask

    task automatic test_dup_miss();
        upd(1, 1, 'h10, 1);
        tick();
        checks++; if (upd_err_vld !== 1'b0) begin failures++; $display("FAIL dup_first got=%b exp=0", upd_err_vld); end
        tick();
        checks++; if (upd_err_code !== 3'd2) begin failures++; $display("FAIL dup_code got=%0d exp=2", upd_err_code); end
        checks++; if (upd_err_prod_id !== 3'd1) begin failures++; $display("FAIL dup_pid got=%0d exp=1", upd_err_prod_id); end
        upd(1, 2, 'h22, 1);
        tick();
        checks++; if (upd_err_code !== 3'd3) begin failures++; $display("FAIL miss_code got=%0d exp=3", upd_err_code); end
        checks++; if (live_cnt[7:4] !== 4'd1) begin failures++; $display("FAIL dup_live got=%0d exp=1", live_cnt[7:4]); end
        idle();
    endtask

    task automatic test_zsize_badprod();
        upd(2, 1, 3, 0);
        tick();
        checks++; if (upd_err_code !== 3'd4) begin failures++; $display("FAIL zsize_code got=%0d exp=4", upd_err_code); end
        checks++; if (live_cnt[11:8] !== 4'd0) begin failures++; $display("FAIL zsize_live got=%0d exp=0", live_cnt[11:8]); end
        upd(5, 1, 1, 1);
        tick();
        checks++; if (upd_err_code !== 3'd5) begin failures++; $display("FAIL badprod_code got=%0d exp=5", upd_err_code); end
        checks++; if (upd_err_prod_id !== 3'd5) begin failures++; $display("FAIL badprod_pid got=%0d exp=5", upd_err_prod_id); end
        idle();
    endtask

    task automatic test_same_cycle();
        upd(3, 1, 7, 1);
        lut(3, 0);
        tick();
        checks++; if (lut_err_vld !== 1'b1) begin failures++; $display("FAIL same_lut got=%b exp=1", lut_err_vld); end
        checks++; if (upd_err_vld !== 1'b0) begin failures++; $display("FAIL same_upd got=%b exp=0", upd_err_vld); end
        idle();
        lut(3, 0);
        tick();
        checks++; if (lut_err_vld !== 1'b0) begin failures++; $display("FAIL next_lut got=%b exp=0", lut_err_vld); end
        checks++; if (live_cnt[15:12] !== 4'd1) begin failures++; $display("FAIL same_live got=%0d exp=1", live_cnt[15:12]); end
        idle();
    endtask

    task automatic test_xval_clear();
        if (x_capable) begin
            upd(0, 1, 0, 5);
            upd_key = 'x;
            lut(0, 0);
            lut_level = 'x;
            tick();
            checks++; if (upd_err_code !== 3'd6) begin failures++; $display("FAIL xval_code got=%0d exp=6", upd_err_code); end
            checks++; if (lut_err_vld !== 1'b1) begin failures++; $display("FAIL xval_lut got=%b exp=1", lut_err_vld); end
            checks++; if (live_cnt[3:0] !== 4'd8) begin failures++; $display("FAIL xval_live got=%0d exp=8", live_cnt[3:0]); end
            idle();
        end
        upd(0, 0, 0, 0);
        upd_key  = 'x;
        upd_size = 'x;
        tick();
        checks++; if (upd_err_vld !== 1'b0) begin failures++; $display("FAIL clear_err got=%b exp=0", upd_err_vld); end
        checks++; if (live_cnt[3:0] !== 4'd0) begin failures++; $display("FAIL clear_live got=%0d exp=0", live_cnt[3:0]); end
        idle();
    endtask

    task automatic test_counter();
        int exp_seq [3] = '{2, 3, 3};
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        upd(5, 1, 1, 1);
        lut(6, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (int'(err_cnt) !== exp_seq[i]) begin failures++; $display("FAIL cnt_step%0d got=%0d exp=%0d", i, err_cnt, exp_seq[i]); end
            checks++; if ({upd_err_vld, lut_err_vld} !== 2'b11) begin failures++; $display("FAIL cnt_pulses%0d got=%b exp=11", i, {upd_err_vld, lut_err_vld}); end
        end
        rst = 1'b1;
        tick();
        checks++; if ({upd_err_vld, upd_err_code, upd_err_prod_id, lut_err_vld, err_sticky, err_cnt, live_cnt} !== '0)
            begin failures++; $display("FAIL midburst_rst got=%b/%0d/%0d/%b/%b/%0d/%h exp=all0", upd_err_vld, upd_err_code,
                upd_err_prod_id, lut_err_vld, err_sticky, err_cnt, live_cnt); end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_random();
        int unsigned model [PN][$];
        int e_cnt, e_code, e_pid, pos, p, r;
        logic e_lut, e_sticky;
        logic [PN*4-1:0] e_live;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        e_cnt = 0;
        e_sticky = 1'b0;
        for (int c = 0; c < 400; c++) begin
            upd_vld = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            upd_prod_id = (r < 9) ? PW'(r % PN) : PW'($urandom_range(PN, 7));
            upd_cmd  = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            upd_key  = 16'($urandom_range(0, 11));
            upd_size = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            lut_vld  = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            lut_prod_id = (r < 9) ? PW'(r % PN) : PW'($urandom_range(PN, 7));
            lut_level   = 3'($urandom_range(0, 7));

            p = int'(lut_prod_id);
            e_lut = lut_vld && ((p >= PN) || (int'(lut_level) >= model[p % PN].size()));

            e_code = 0;
            p = int'(upd_prod_id);
            if (upd_vld) begin
                if (p >= PN) e_code = 5;
                else begin
                    pos = -1;
                    foreach (model[p][i]) if (model[p][i] == int'(upd_key)) pos = i;
                    case (upd_cmd)
                        2'd0: model[p].delete();
                        2'd1: if (upd_size == 0) e_code = 4;
                              else if (pos >= 0) e_code = 2;
                              else if (model[p].size() == EN) e_code = 1;
                              else model[p].push_back(int'(upd_key));
                        2'd2: if (pos < 0) e_code = 3; else model[p].delete(pos);
                        default: if (upd_size == 0) e_code = 4; else if (pos < 0) e_code = 3;
                    endcase
                end
            end
            e_pid = (e_code != 0) ? p : 0;
            e_cnt = e_cnt + ((e_code != 0) ? 1 : 0) + (e_lut ? 1 : 0);
            if (e_cnt > CNT_MAX) e_cnt = CNT_MAX;
            e_sticky = e_sticky | (e_code != 0) | e_lut;
            for (int q = 0; q < PN; q++) e_live[4*q +: 4] = 4'(model[q].size());

            tick();
            checks++; if (upd_err_vld !== (e_code != 0)) begin failures++; $display("FAIL rnd%0d_upd_vld got=%b exp=%b", c, upd_err_vld, e_code != 0); end
            checks++; if (int'(upd_err_code) !== e_code) begin failures++; $display("FAIL rnd%0d_code got=%0d exp=%0d", c, upd_err_code, e_code); end
            checks++; if (int'(upd_err_prod_id) !== e_pid) begin failures++; $display("FAIL rnd%0d_pid got=%0d exp=%0d", c, upd_err_prod_id, e_pid); end
            checks++; if (lut_err_vld !== e_lut) begin failures++; $display("FAIL rnd%0d_lut got=%b exp=%b", c, lut_err_vld, e_lut); end
            checks++; if (int'(err_cnt) !== e_cnt) begin failures++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", c, err_cnt, e_cnt); end
            checks++; if (err_sticky !== e_sticky) begin failures++; $display("FAIL rnd%0d_sticky got=%b exp=%b", c, err_sticky, e_sticky); end
            checks++; if (live_cnt !== e_live) begin failures++; $display("FAIL rnd%0d_live got=%h exp=%h", c, live_cnt, e_live); end
        end
        idle();
    endtask

    initial begin
        logic xt;
        xt = 1'bx;
        x_capable = $isunknown(xt);
        rst = 1'b1;
        idle();
        test_reset();
        test_full();
        test_dup_miss();
        test_zsize_badprod();
        test_same_cycle();
        test_xval_clear();
        test_counter();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
